// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: IDLE -> READ -> DONE per fetch, timeout abort, misalign error.
// Optional one-entry hit bypass enabled by defining IFETCH_HIT_BYPASS_EN.
module ifetch_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic [31:0] PCaddr,
   output logic        iready,
   output logic [31:0] instruction,
   output logic        fetch_err,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic [1:0]  dbg_state
);

   // Memory handshake: mem_read/mem_addr are held for the whole READ state;
   // the beat completes on any rising edge in READ where mem_busy is low,
   // and mem_rdata is only sampled on that edge.

   localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              misaligned;
   logic              cnt_expired;
   logic              tag_hit;

   assign misaligned  = (PCaddr[1:0] != 2'b00);
   assign cnt_expired = (wait_q == CNT_LAST);

`ifdef IFETCH_HIT_BYPASS_EN
   logic [31:0] tag_q;
   logic        tag_vld_q;

   assign tag_hit = tag_vld_q && (PCaddr == tag_q);

   // Tag tracks the last address whose data actually came from memory.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         tag_q     <= '0;
         tag_vld_q <= 1'b0;
      end else if (state_q == READ && !mem_busy) begin
         tag_q     <= addr_q;
         tag_vld_q <= 1'b1;
      end else if ((state_q == IDLE && misaligned) ||
                   (state_q == READ && mem_busy && cnt_expired)) begin
         tag_vld_q <= 1'b0;
      end
   end
`else
   assign tag_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      err_d   = err_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            addr_d = PCaddr;
            wait_d = '0;
            err_d  = 1'b0;
            if (misaligned) begin
               instr_d = NOP_INSTR;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (tag_hit) begin
               state_d = DONE;
            end else begin
               state_d = READ;
            end
         end
         READ: begin
            // Data arriving on the last allowed cycle beats the timeout.
            if (!mem_busy) begin
               instr_d = mem_rdata;
               state_d = DONE;
            end else if (cnt_expired) begin
               instr_d = NOP_INSTR;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_read    = (state_q == READ);
   assign mem_addr    = addr_q;
   assign iready      = (state_q == DONE);
   assign fetch_err   = (state_q == DONE) && err_q;
   assign instruction = instr_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: latency, busy/timeout boundary, misalign, reset abort, hit bypass.
module tb_ifetch_responder;

   localparam int          TO  = 6;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        tb_clk = 1'b0;
   logic        nRST;
   logic [31:0] PCaddr;
   logic        iready;
   logic [31:0] instruction;
   logic        fetch_err;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 tb_clk = ~tb_clk;

   ifetch_responder #(
      .TIMEOUT_CYCLES(TO),
      .NOP_INSTR(NOP)
   ) u_dut (
      .clk(tb_clk),
      .nRST(nRST),
      .PCaddr(PCaddr),
      .iready(iready),
      .instruction(instruction),
      .fetch_err(fetch_err),
      .mem_read(mem_read),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .mem_busy(mem_busy),
      .dbg_state(dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts at a negedge with the DUT in IDLE; ends at the negedge of the following IDLE.
   task automatic run_fetch(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                            input int busy_n, input logic [31:0] exp_instr, input logic exp_err,
                            input int exp_lat, input int exp_reads);
      int lat;
      int reads;
      int busy_left;
      logic [31:0] exp_w;
      lat       = 1;
      reads     = 0;
      busy_left = busy_n;
      exp_q.push_back(exp_instr);
      PCaddr    = addr;
      mem_busy  = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      check_eq({tag, "_idle"}, {30'd0, iready, mem_read}, 32'd0);
      while (!iready && lat < 40) begin
         if (mem_read) begin
            reads++;
            check_eq({tag, "_addr"}, mem_addr, addr);
            PCaddr    = addr ^ 32'h100;
            mem_busy  = (busy_left > 0);
            mem_rdata = (busy_left > 0) ? 32'hDEADBEEF : rdata;
            if (busy_left > 0) busy_left--;
         end
         @(posedge tb_clk);
         @(negedge tb_clk);
         lat++;
      end
      check_eq({tag, "_done"}, {31'd0, iready}, 32'd1);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_reads"}, reads, exp_reads);
      check_eq({tag, "_err"}, {31'd0, fetch_err}, {31'd0, exp_err});
      exp_w = exp_q.pop_front();
      check_eq({tag, "_instr"}, instruction, exp_w);
      PCaddr = addr;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_eq({tag, "_pulse"}, {29'd0, iready, fetch_err, mem_read}, 32'd0);
      check_eq({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
      check_eq({tag, "_hold"}, instruction, exp_w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST      = 1'b1;
      PCaddr    = 32'h0;
      mem_rdata = 32'h0;
      mem_busy  = 1'b0;
      #1 nRST = 1'b0;
      repeat (2) @(negedge tb_clk);
      check_eq("rst_outs", {29'd0, iready, fetch_err, mem_read}, 32'd0);
      check_eq("rst_addr", mem_addr, 32'h0);
      check_eq("rst_instr", instruction, NOP);
      check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
      nRST = 1'b1;

      run_fetch("basic0", 32'h0, 32'h00500093, 0, 32'h00500093, 1'b0, 3, 1);
      run_fetch("busy5", 32'h4, 32'hFE000EE3, TO - 1, 32'hFE000EE3, 1'b0, TO + 2, TO);
      run_fetch("misal6", 32'h6, 32'h12345678, 0, NOP, 1'b1, 2, 0);
      run_fetch("tmo_stuck", 32'hC, 32'h0, 100, NOP, 1'b1, TO + 2, TO);
      run_fetch("tmo_edge", 32'h20, 32'h0, TO, NOP, 1'b1, TO + 2, TO);
      run_fetch("after_tmo", 32'h14, 32'h00208113, 2, 32'h00208113, 1'b0, 5, 3);
      run_fetch("hit_first", 32'h10, 32'h00108093, 0, 32'h00108093, 1'b0, 3, 1);
`ifdef IFETCH_HIT_BYPASS_EN
      run_fetch("hit_second", 32'h10, 32'h11111111, 0, 32'h00108093, 1'b0, 2, 0);
`else
      run_fetch("hit_second", 32'h10, 32'h11111111, 0, 32'h11111111, 1'b0, 3, 1);
`endif
      run_fetch("misal12", 32'h12, 32'h0, 0, NOP, 1'b1, 2, 0);
      run_fetch("refill10", 32'h10, 32'h22222222, 0, 32'h22222222, 1'b0, 3, 1);

      // Abort a stalled read with reset, then refetch the same address.
      PCaddr   = 32'h8;
      mem_busy = 1'b1;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_eq("rst_mid_read", {31'd0, mem_read}, 32'd1);
      #1 nRST = 1'b0;
      #1;
      check_eq("rst_mid_outs", {29'd0, iready, fetch_err, mem_read}, 32'd0);
      check_eq("rst_mid_instr", instruction, NOP);
      check_eq("rst_mid_addr", mem_addr, 32'h0);
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_eq("rst_mid_noready", {31'd0, iready}, 32'd0);
      nRST = 1'b1;
      run_fetch("refetch8", 32'h8, 32'h00A00113, 0, 32'h00A00113, 1'b0, 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
